wb_charlie7x5_ctrl: RTL
=======================

Name: wb_charlie7x5_ctrl

Overview:
Scan controller for the 7-pin charlieplexed 7x5 LED matrix. It holds a double-buffered 35-pixel framebuffer that is written over a Wishbone B4 pipelined slave port. It sequences one pixel at a time onto the tri-state charlie7x5_o/charlie7x5_oe pins, with a blanking gap between pixels and a constant dwell per pixel. It sits between the system Wishbone interconnect and the matrix I/O pads.

Parameters:
DWELL, 64, clock cycles each pixel slot is driven (lit or dark); must be >= 1
BLANK, 2, clock cycles with all pins tri-stated before each pixel slot; must be >= 1

Ports:
wb_clk_i  input  1  system clock; sole clock domain
wb_rst_i  input  1  asynchronous active-high reset
wb_cyc_i  input  1  Wishbone cycle
wb_stb_i  input  1  Wishbone strobe
wb_we_i  input  1  write enable
wb_adr_i  input  4  register address
wb_dat_i  input  8  write data
wb_dat_o  output  8  read data, valid with ack
wb_ack_o  output  1  acknowledge
wb_stall_o  output  1  stall; tied 0
charlie7x5_o  output  7  pin output values
charlie7x5_oe  output  7  pin output enables; 0 = tri-state
frame_o  output  1  one-cycle pulse at each frame end

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values: all outputs 0; both buffers 0; enable = 0; swap_pending = 0; scan at col 0, row 0; state IDLE.
- Register map:
  - 0..6: back-buffer column c, bits[4:0] = rows 0..4; bits[7:5] read 0.
  - 7: CTRL. Bit0 = enable (R/W). Bit1 = swap request on write of 1; reads return swap_pending.
  - 8..15: reads return 0, writes are ignored.
- Bus handshake:
  - Every cyc&stb cycle is accepted; wb_stall_o is always 0.
  - wb_ack_o is asserted exactly 1 cycle after acceptance, with wb_dat_o registered at the same time.
  - Back-to-back strobes give back-to-back acks.
  - wb_dat_o = 0 when ack is low.
- Pin mapping for pixel (c, r):
  - row_pin = (r >= c) ? r+1 : r; col_pin = c.
  - Lit: charlie7x5_o = 1<<row_pin; charlie7x5_oe = (1<<row_pin) | (1<<col_pin).
  - Dark, IDLE or BLANK: o = 0, oe = 0.
- State machine (the pin outputs are registered):
  - IDLE: pins tri-stated. Go to BLANK when enable = 1.
  - BLANK: hold BLANK cycles. Then go to DRIVE.
  - DRIVE: hold DWELL cycles, lit only if front[c][r] = 1. Then advance r 0..4; on r wrap, advance c 0..6. Then go to BLANK.
  - After pixel (6,4) completes, the frame ends: pulse frame_o; if swap_pending, copy back to front and clear swap_pending; wrap to (0,0).
  - Frame period = 35*(BLANK+DWELL) cycles; 2310 at defaults.
- Enable cleared mid-frame: on the next cycle, pins go to 0, state goes to IDLE and the scan resets to (0,0). No frame_o pulse.
- Swap while IDLE: a pending swap is applied on the next cycle.
- Simultaneous events:
  - Swap request written in the same cycle as a frame end: the swap is applied at the following frame end.
  - Back-buffer write in the same cycle as a swap copy: the copy takes the pre-write value; the write lands in the back buffer only.
- Front-buffer consistency: the front buffer changes only at a frame end or in IDLE. A displayed frame is never torn.
- Reset asserted mid-frame: all state returns immediately to the reset values.

Test Plan:
- Reset, then read addresses 0..8 -> each ack arrives 1 cycle after strobe; all data 0; pins o = 0, oe = 0.
- Write 0x1F to addr 0, then 0x03 (enable+swap) to addr 7 -> the first frame is dark and frame_o pulses at cycle 2310 after enable. In the next frame, pixel (0,0) gives o = 0x02, oe = 0x03, and pixel (0,4) gives o = 0x20, oe = 0x21, each for 64 cycles preceded by 2 cycles of oe = 0.
- Write addr 6 = 0x10, swap, enable -> pixel (6,4) gives o = 0x10, oe = 0x50. A read of addr 7 returns 0x01 after the swap.
- Issue 4 back-to-back writes with cyc/stb held -> 4 consecutive acks, stall never asserted, readback matches.
- Clear enable during DRIVE of pixel (2,3) -> next cycle oe = 0. Re-enabling restarts at pixel (0,0) after BLANK.
- Write swap exactly on the frame_o cycle -> front is unchanged for that frame and updated at the next frame_o.

Source files
------------

// File: rtl/wb_charlie7x5_ctrl.sv
// Wishbone B4 pipelined scan controller for a 7-pin charlieplexed 7x5 LED matrix.
// Double-buffered framebuffer, one pixel lit at a time with a blanking gap between slots.
module wb_charlie7x5_ctrl #(
  parameter int unsigned DWELL = 64,
  parameter int unsigned BLANK = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       wb_stall_o,
  output logic [6:0] charlie7x5_o,
  output logic [6:0] charlie7x5_oe,
  output logic       frame_o
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [3:0]    ADR_CTRL   = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        col_q, col_d;
  logic [2:0]        row_q, row_d;
  logic              enable_q, enable_d;
  logic              swap_pending_q, swap_pending_d;
  logic [6:0][4:0]   back_q, back_d;
  logic [6:0][4:0]   front_q, front_d;
  logic              ack_q, ack_d;
  logic [7:0]        dat_q, dat_d;
  logic [6:0]        pin_o_q, pin_o_d;
  logic [6:0]        pin_oe_q, pin_oe_d;
  logic              frame_q, frame_d;

  logic              bus_acc;
  logic              bus_wr;
  logic              swap_req;
  logic              apply_swap;
  logic [7:0]        rd_data;
  logic [2:0]        row_pin;
  logic              unused_dat_bits;

  // Column registers only hold five row bits; the top write bits are discarded.
  assign unused_dat_bits = ^wb_dat_i[7:5];

  // ---------------------------------------------------------------------------
  // Bus side: accept every strobe, register the read data with the ack.
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    bus_acc  = wb_cyc_i & wb_stb_i;
    bus_wr   = bus_acc & wb_we_i;
    back_d   = back_q;
    enable_d = enable_q;
    swap_req = 1'b0;
    rd_data  = 8'h00;

    for (int c = 0; c < 7; c++) begin
      if (wb_adr_i == 4'(c)) begin
        rd_data = {3'b000, back_q[c]};
      end
    end
    if (wb_adr_i == ADR_CTRL) begin
      rd_data = {6'b000000, swap_pending_q, enable_q};
    end

    ack_d = bus_acc;
    dat_d = (bus_acc && !wb_we_i) ? rd_data : 8'h00;

    if (bus_wr) begin
      for (int c = 0; c < 7; c++) begin
        if (wb_adr_i == 4'(c)) begin
          back_d[c] = wb_dat_i[4:0];
        end
      end
      if (wb_adr_i == ADR_CTRL) begin
        enable_d = wb_dat_i[0];
        swap_req = wb_dat_i[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM. A write that clears enable takes effect on the accepting edge,
  // so the pins are dark in the very next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    col_d          = col_q;
    row_d          = row_q;
    front_d        = front_q;
    swap_pending_d = swap_pending_q;
    frame_d        = 1'b0;
    apply_swap     = 1'b0;

    if (!enable_d) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      col_d   = 3'd0;
      row_d   = 3'd0;
      if (state_q == ST_IDLE && swap_pending_q) begin
        apply_swap = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (swap_pending_q) begin
            apply_swap = 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (row_q == 3'd4) begin
              row_d = 3'd0;
              if (col_q == 3'd6) begin
                // Last pixel of the frame: the only point where the front buffer may change.
                col_d   = 3'd0;
                frame_d = 1'b1;
                if (swap_pending_q) begin
                  apply_swap = 1'b1;
                end
              end else begin
                col_d = col_q + 3'd1;
              end
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          col_d   = 3'd0;
          row_d   = 3'd0;
        end
      endcase
    end

    // Copy uses the pre-write back buffer; a new request in the same cycle survives.
    if (apply_swap) begin
      front_d        = back_q;
      swap_pending_d = 1'b0;
    end
    if (swap_req) begin
      swap_pending_d = 1'b1;
    end
  end

  // Pins are computed from the next scan position so they register in step with it.
  always_comb begin
    pin_o_d  = 7'h00;
    pin_oe_d = 7'h00;
    row_pin  = (row_d >= col_d) ? row_d + 3'd1 : row_d;
    if (state_d == ST_DRIVE && front_q[col_d][row_d]) begin
      pin_o_d  = 7'h01 << row_pin;
      pin_oe_d = (7'h01 << row_pin) | (7'h01 << col_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: both pixel buffers are small register files and are cleared by reset like any other state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      col_q          <= 3'd0;
      row_q          <= 3'd0;
      enable_q       <= 1'b0;
      swap_pending_q <= 1'b0;
      back_q         <= '0;
      front_q        <= '0;
      ack_q          <= 1'b0;
      dat_q          <= 8'h00;
      pin_o_q        <= 7'h00;
      pin_oe_q       <= 7'h00;
      frame_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      col_q          <= col_d;
      row_q          <= row_d;
      enable_q       <= enable_d;
      swap_pending_q <= swap_pending_d;
      back_q         <= back_d;
      front_q        <= front_d;
      ack_q          <= ack_d;
      dat_q          <= dat_d;
      pin_o_q        <= pin_o_d;
      pin_oe_q       <= pin_oe_d;
      frame_q        <= frame_d;
    end
  end

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign wb_stall_o    = 1'b0;
  assign charlie7x5_o  = pin_o_q;
  assign charlie7x5_oe = pin_oe_q;
  assign frame_o       = frame_q;

endmodule
